pcie3_cfg_mesg_rcvd_assembler: RTL and testbench

- Receive-side counterpart of the cfg message transmit path.
- Watches the PCIe3 cfg "message received" interface (received / received_type / received_data), where one message is a contiguous run of received=1 cycles carrying one data unit per cycle.
- Packs each run into a single wide record and buffers records in a small FIFO.
- Presents records to the management logic on a valid/ready interface and counts any records dropped on overflow.

---
 rtl/pcie3_cfg_mesg_rcvd_assembler_if.sv | 31 +++
 rtl/pcie3_cfg_mesg_rcvd_assembler.sv | 146 ++++++++++++++
 tb/tb_pcie3_cfg_mesg_rcvd_assembler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie3_cfg_mesg_rcvd_assembler_if.sv
// rtl/pcie3_cfg_mesg_rcvd_assembler_if.sv - cfg message-received input and record output bundle
interface pcie3_cfg_mesg_rcvd_assembler_if #(
    parameter int C_RECEIVED_TYPE_WIDTH = 5,
    parameter int C_RECEIVED_DATA_WIDTH = 8,
    parameter int C_MAX_UNITS           = 8,
    parameter int C_LEN_WIDTH           = 5
);
    logic                                         s_received;
    logic [C_RECEIVED_TYPE_WIDTH-1:0]             s_received_type;
    logic [C_RECEIVED_DATA_WIDTH-1:0]             s_received_data;
    logic                                         m_valid;
    logic                                         m_ready;
    logic [C_RECEIVED_TYPE_WIDTH-1:0]             m_type;
    logic [C_MAX_UNITS*C_RECEIVED_DATA_WIDTH-1:0] m_data;
    logic [C_LEN_WIDTH-1:0]                       m_len;
    logic                                         m_trunc;
    logic                                         m_type_err;
    logic [15:0]                                  drop_cnt;

    // Assembler side: consumes the received strobe, produces records
    modport slave (
        input  s_received, s_received_type, s_received_data, m_ready,
        output m_valid, m_type, m_data, m_len, m_trunc, m_type_err, drop_cnt
    );

    // Environment side: drives the received strobe, consumes records
    modport master (
        output s_received, s_received_type, s_received_data, m_ready,
        input  m_valid, m_type, m_data, m_len, m_trunc, m_type_err, drop_cnt
    );
endinterface

// File: rtl/pcie3_cfg_mesg_rcvd_assembler.sv
// rtl/pcie3_cfg_mesg_rcvd_assembler.sv - packs received cfg messages into records and queues them
module pcie3_cfg_mesg_rcvd_assembler #(
    parameter int C_RECEIVED_TYPE_WIDTH = 5,
    parameter int C_RECEIVED_DATA_WIDTH = 8,
    parameter int C_MAX_UNITS           = 8,
    parameter int C_FIFO_DEPTH          = 4,
    parameter int C_LEN_WIDTH           = 5
) (
    input logic                            aclk,
    input logic                            areset,
    pcie3_cfg_mesg_rcvd_assembler_if.slave bus
);
    localparam int TW = C_RECEIVED_TYPE_WIDTH;
    localparam int DW = C_RECEIVED_DATA_WIDTH;
    localparam int MW = C_MAX_UNITS * DW;
    localparam int LW = C_LEN_WIDTH;
    localparam int RW = TW + MW + LW + 2;
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [LW-1:0] MAX_LEN  = LW'(C_MAX_UNITS);
    localparam logic [OW-1:0] FULL_OCC = OW'(C_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_LOW} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            commit;

    logic [TW-1:0]   cap_type;
    logic [MW-1:0]   cap_data;
    logic [LW-1:0]   cap_len;
    logic            cap_trunc;
    logic            cap_err;

    logic [RW-1:0]   fifo_mem [C_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;
    logic            push;
    logic            pop;
    logic            full;
    logic [RW-1:0]   head;
    logic [15:0]     drop_cnt;

    // State register; a run already in progress at reset is skipped via WAIT_LOW
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= bus.s_received ? WAIT_LOW : IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the first low cycle after a run is the commit cycle
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.s_received) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (!bus.s_received) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!bus.s_received) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the running message: type, packed units, count and error flags
    always_ff @(posedge aclk) begin
        if (areset) begin
            cap_type  <= '0;
            cap_data  <= '0;
            cap_len   <= '0;
            cap_trunc <= 1'b0;
            cap_err   <= 1'b0;
        end else if (bus.s_received) begin
            if (state == IDLE) begin
                cap_type           <= bus.s_received_type;
                cap_data           <= '0;
                cap_data[DW-1:0]   <= bus.s_received_data;
                cap_len            <= LW'(1);
                cap_trunc          <= 1'b0;
                cap_err            <= 1'b0;
            end else if (state == COLLECT) begin
                if (cap_len < MAX_LEN) begin
                    cap_data[int'(cap_len)*DW +: DW] <= bus.s_received_data;
                    cap_len                          <= cap_len + LW'(1);
                end else begin
                    cap_trunc <= 1'b1;
                end
                if (bus.s_received_type != cap_type) cap_err <= 1'b1;
            end
        end
    end

    assign full = (occ == FULL_OCC);
    assign pop  = bus.m_valid && bus.m_ready;
    assign push = commit && (!full || pop);

    // Record FIFO pointers and occupancy
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Record storage; contents need no reset because outputs are gated by m_valid
    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr] <= {cap_type, cap_data, cap_len, cap_trunc, cap_err};
    end

    // Saturating count of records lost to a full FIFO
    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_cnt <= '0;
        end else if (commit && !push && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign head           = fifo_mem[rd_ptr];
    assign bus.m_valid    = (occ != '0);
    assign bus.m_type     = bus.m_valid ? head[RW-1 -: TW]       : '0;
    assign bus.m_data     = bus.m_valid ? head[LW+2 +: MW]       : '0;
    assign bus.m_len      = bus.m_valid ? head[2 +: LW]          : '0;
    assign bus.m_trunc    = bus.m_valid ? head[1]                : 1'b0;
    assign bus.m_type_err = bus.m_valid ? head[0]                : 1'b0;
    assign bus.drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_pcie3_cfg_mesg_rcvd_assembler.sv
// tb/tb_pcie3_cfg_mesg_rcvd_assembler.sv - self-checking bench for the cfg message assembler
module tb_pcie3_cfg_mesg_rcvd_assembler;
    localparam int TW = 5;
    localparam int DW = 8;
    localparam int MU = 8;
    localparam int FD = 4;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    pcie3_cfg_mesg_rcvd_assembler_if #(
        .C_RECEIVED_TYPE_WIDTH(TW), .C_RECEIVED_DATA_WIDTH(DW),
        .C_MAX_UNITS(MU), .C_LEN_WIDTH(LW)
    ) bus ();

    pcie3_cfg_mesg_rcvd_assembler #(
        .C_RECEIVED_TYPE_WIDTH(TW), .C_RECEIVED_DATA_WIDTH(DW),
        .C_MAX_UNITS(MU), .C_FIFO_DEPTH(FD), .C_LEN_WIDTH(LW)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int           n;
        logic [4:0]   t1;
        logic [4:0]   t2;
        int           chg;
        logic [7:0]   d0;
        logic [7:0]   ds;
        logic [4:0]   et;
        logic [4:0]   el;
        logic [63:0]  ed;
        logic         etr;
        logic         eer;
    } vec_t;

    typedef struct {
        logic [4:0]  t;
        logic [63:0] d;
        logic [4:0]  len;
        logic        tr;
        logic        er;
    } rec_t;

    vec_t vec [6];

    bit          model_on = 0;
    rec_t        mq [$];
    logic [7:0]  units [$];
    logic [4:0]  mtype;
    bit          terr;
    bit          in_msg;
    bit          wait_low;
    logic [15:0] mdrop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // reference: per-edge update over queues of units and records
    task automatic model_edge();
        int   sz;
        bit   p;
        rec_t r;
        if (areset) begin
            mq.delete();
            units.delete();
            mdrop    = 0;
            in_msg   = 0;
            wait_low = bus.s_received;
            return;
        end
        sz = mq.size();
        p  = (sz > 0) && bus.m_ready;
        if (wait_low) begin
            if (!bus.s_received) wait_low = 0;
        end else if (bus.s_received) begin
            if (!in_msg) begin
                in_msg = 1;
                units.delete();
                mtype = bus.s_received_type;
                terr  = 0;
            end else if (bus.s_received_type != mtype) begin
                terr = 1;
            end
            units.push_back(bus.s_received_data);
        end else if (in_msg) begin
            in_msg = 0;
            r.t   = mtype;
            r.d   = 64'h0;
            for (int i = 0; i < units.size() && i < MU; i++) r.d[i*8 +: 8] = units[i];
            r.len = (units.size() > MU) ? 5'(MU) : 5'(units.size());
            r.tr  = units.size() > MU;
            r.er  = terr;
            if (p) void'(mq.pop_front());
            if (sz < FD || p) mq.push_back(r);
            else if (mdrop != 16'hFFFF) mdrop++;
            return;
        end
        if (p) void'(mq.pop_front());
    endtask

    task automatic cyc();
        @(posedge clk);
        if (model_on) model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [4:0] t, input logic [7:0] d);
        bus.s_received      = r;
        bus.s_received_type = t;
        bus.s_received_data = d;
        cyc();
    endtask

    task automatic pop_one();
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
    endtask

    initial begin
        logic [4:0] tv;
        logic [7:0] dv;
        logic [63:0] hold;
        bit   sr;
        logic [4:0] cur_t;
        int   rdy_pct;

        vec[0] = '{4,  5'h10, 5'h10, 99, 8'h11, 8'h11, 5'h10, 5'd4, 64'h0000_0000_4433_2211, 1'b0, 1'b0};
        vec[1] = '{10, 5'h04, 5'h04, 99, 8'h01, 8'h01, 5'h04, 5'd8, 64'h0807_0605_0403_0201, 1'b1, 1'b0};
        vec[2] = '{4,  5'h02, 5'h03, 2,  8'hA0, 8'h01, 5'h02, 5'd4, 64'h0000_0000_A3A2_A1A0, 1'b0, 1'b1};
        vec[3] = '{1,  5'h1F, 5'h1F, 99, 8'hFF, 8'h00, 5'h1F, 5'd1, 64'h0000_0000_0000_00FF, 1'b0, 1'b0};
        vec[4] = '{8,  5'h07, 5'h07, 99, 8'h10, 8'h10, 5'h07, 5'd8, 64'h8070_6050_4030_2010, 1'b0, 1'b0};
        vec[5] = '{9,  5'h01, 5'h01, 99, 8'h11, 8'h11, 5'h01, 5'd8, 64'h8877_6655_4433_2211, 1'b1, 1'b0};

        areset = 1'b1;
        bus.s_received = 1'b0;
        bus.s_received_type = '0;
        bus.s_received_data = '0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        areset = 1'b0;
        cyc();
        chk("reset_valid", 64'(bus.m_valid), 0);
        chk("reset_type", 64'(bus.m_type), 0);
        chk("reset_data", bus.m_data, 0);
        chk("reset_len", 64'(bus.m_len), 0);
        chk("reset_trunc", 64'(bus.m_trunc), 0);
        chk("reset_err", 64'(bus.m_type_err), 0);
        chk("reset_drop", 64'(bus.drop_cnt), 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vec[v].n; i++) begin
                tv = (i >= vec[v].chg) ? vec[v].t2 : vec[v].t1;
                dv = 8'(vec[v].d0 + 8'(i) * vec[v].ds);
                drive(1'b1, tv, dv);
            end
            chk($sformatf("v%0d_commit_cycle_valid", v), 64'(bus.m_valid), 0);
            drive(1'b0, 5'($urandom), 8'($urandom));
            chk($sformatf("v%0d_valid", v), 64'(bus.m_valid), 1);
            chk($sformatf("v%0d_type", v), 64'(bus.m_type), 64'(vec[v].et));
            chk($sformatf("v%0d_len", v), 64'(bus.m_len), 64'(vec[v].el));
            chk($sformatf("v%0d_data", v), bus.m_data, vec[v].ed);
            chk($sformatf("v%0d_trunc", v), 64'(bus.m_trunc), 64'(vec[v].etr));
            chk($sformatf("v%0d_err", v), 64'(bus.m_type_err), 64'(vec[v].eer));
            hold = bus.m_data;
            cyc();
            chk($sformatf("v%0d_hold_data", v), bus.m_data, hold);
            pop_one();
            chk($sformatf("v%0d_empty_after_pop", v), 64'(bus.m_valid), 0);
        end

        // overflow: six single-unit messages into a depth-4 FIFO
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 5'h01, 8'(k));
            drive(1'b0, 5'h00, 8'h00);
        end
        chk("ovf_drop_cnt", 64'(bus.drop_cnt), 2);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_valid_%0d", k), 64'(bus.m_valid), 1);
            chk($sformatf("ovf_order_%0d", k), bus.m_data, 64'(k));
            pop_one();
        end
        chk("ovf_valid_falls", 64'(bus.m_valid), 0);

        // full FIFO with a pop exactly on the commit cycle
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'h00, 8'(8'h20 + k));
            drive(1'b0, 5'h00, 8'h00);
        end
        drive(1'b1, 5'h00, 8'h25);
        bus.m_ready = 1'b1;
        drive(1'b0, 5'h00, 8'h00);
        bus.m_ready = 1'b0;
        chk("fullpop_drop_cnt", 64'(bus.drop_cnt), 2);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("fullpop_valid_%0d", k), 64'(bus.m_valid), 1);
            chk($sformatf("fullpop_order_%0d", k), bus.m_data, 64'(8'h20 + k));
            pop_one();
        end
        chk("fullpop_occupancy_4", 64'(bus.m_valid), 0);

        // reset during the third unit of a five-unit run
        drive(1'b1, 5'h07, 8'hA1);
        drive(1'b1, 5'h07, 8'hA2);
        areset = 1'b1;
        drive(1'b1, 5'h07, 8'hA3);
        areset = 1'b0;
        drive(1'b1, 5'h07, 8'hA4);
        drive(1'b1, 5'h07, 8'hA5);
        drive(1'b0, 5'h00, 8'h00);
        cyc();
        chk("rst_mid_valid", 64'(bus.m_valid), 0);
        chk("rst_mid_data", bus.m_data, 0);
        chk("rst_mid_type", 64'(bus.m_type), 0);
        chk("rst_mid_len", 64'(bus.m_len), 0);
        chk("rst_mid_drop", 64'(bus.drop_cnt), 0);
        drive(1'b1, 5'h0C, 8'h5A);
        drive(1'b1, 5'h0C, 8'hA5);
        drive(1'b0, 5'h00, 8'h00);
        chk("rst_next_valid", 64'(bus.m_valid), 1);
        chk("rst_next_data", bus.m_data, 64'hA55A);
        chk("rst_next_len", 64'(bus.m_len), 2);
        chk("rst_next_type", 64'(bus.m_type), 64'h0C);
        pop_one();

        // randomized traffic against the queue model
        areset = 1'b1;
        model_on = 1;
        cyc();
        areset = 1'b0;
        sr = 0;
        cur_t = 5'h0;
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rdy_pct = (c / 500 % 3 == 0) ? 10 : ((c / 500 % 3 == 1) ? 90 : 50);
            if (sr) sr = ($urandom_range(0, 99) < 80);
            else begin
                sr = ($urandom_range(0, 1) == 1);
                if (sr) cur_t = 5'($urandom);
            end
            bus.m_ready = ($urandom_range(0, 99) < rdy_pct);
            areset = ($urandom_range(0, 299) == 0);
            tv = ($urandom_range(0, 15) == 0) ? 5'($urandom) : cur_t;
            drive(sr, tv, 8'($urandom));
            chk("rnd_valid", 64'(bus.m_valid), 64'(mq.size() > 0));
            chk("rnd_drop", 64'(bus.drop_cnt), 64'(mdrop));
            if (mq.size() > 0) begin
                chk("rnd_type", 64'(bus.m_type), 64'(mq[0].t));
                chk("rnd_data", bus.m_data, mq[0].d);
                chk("rnd_len", 64'(bus.m_len), 64'(mq[0].len));
                chk("rnd_trunc", 64'(bus.m_trunc), 64'(mq[0].tr));
                chk("rnd_err", 64'(bus.m_type_err), 64'(mq[0].er));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
